// File: rtl/iv_port_bank_if.sv
// IV bus and TX FIFO stream signals between the 8X305 side and one iv_port_bank.
// The master side drives the selects, strobes, CPU data and consumer ready.
interface iv_port_bank_if;
    logic       LB;
    logic       RB;
    logic       SC;
    logic       WC;
    logic [7:0] iv_in;
    logic [7:0] iv_out;
    logic       iv_oe;
    logic [7:0] fifo_data;
    logic       fifo_valid;
    logic       fifo_ready;

    modport master (
        output LB, RB, SC, WC, iv_in, fifo_ready,
        input  iv_out, iv_oe, fifo_data, fifo_valid
    );

    modport slave (
        input  LB, RB, SC, WC, iv_in, fifo_ready,
        output iv_out, iv_oe, fifo_data, fifo_valid
    );
endinterface

// File: rtl/iv_port_bank.sv
// Addressable 8X305 IV-bus peripheral bank: byte latches with read-back,
// an optional TX FIFO behind one port, and a status/flag port.
module iv_port_bank #(
    parameter int         BANK       = 0,
    parameter logic [7:0] BASE_ADDR  = 8'h00,
    parameter int         NPORTS     = 4,
    parameter int         FIFO_PORT  = 0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    iv_port_bank_if.slave       bus,
    output logic [8*NPORTS-1:0] port_q,
    output logic                irq
);

    localparam bit              FIFO_EN = (FIFO_PORT < NPORTS);
    localparam int              PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0]      NP8     = 8'(NPORTS);
    localparam logic [7:0]      FP8     = 8'(FIFO_PORT);
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    // The bus carries every byte inverted and bit-reversed; the coding is its own inverse.
    function automatic logic [7:0] iv_code(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = ~x[7-i];
        return r;
    endfunction

    logic [7:0]    addr_q, addr_d;
    logic [7:0]    latch_q [NPORTS];
    logic [7:0]    latch_d [NPORTS];
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, unf_q, unf_d, irq_q, irq_d;

    logic [7:0] v_in, off, rd_val, stat_val;
    logic [6:0] count_w;
    logic       sel, hit_port, hit_stat, hit_fifo;
    logic       sc_cyc, wr_cyc, rd_cyc;
    logic       full, pop, push, push_ok, ovf_set, unf_set, stat_wr;

    always_comb begin
        v_in     = iv_code(bus.iv_in);
        sel      = ((BANK != 0) ? !bus.RB : !bus.LB) && (bus.LB != bus.RB);
        off      = addr_q - BASE_ADDR;
        hit_port = off < NP8;
        hit_stat = off == NP8;
        hit_fifo = FIFO_EN && (off == FP8);
        sc_cyc   = sel && bus.SC;
        wr_cyc   = sel && bus.WC && !bus.SC;
        rd_cyc   = sel && !bus.SC && !bus.WC;
        full     = count_q == DEPTH_C;
        pop      = (count_q != '0) && bus.fifo_ready;
        push     = wr_cyc && hit_fifo;
        push_ok  = push && (!full || pop);
        ovf_set  = push && full && !pop;
        unf_set  = rd_cyc && hit_fifo && (count_q == '0);
        stat_wr  = wr_cyc && hit_stat;
    end

    always_comb begin
        addr_d   = sc_cyc ? v_in : addr_q;
        latch_d  = latch_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < NPORTS; i++) begin
            if (wr_cyc && off == 8'(i)) latch_d[i] = v_in;
        end
        if (push_ok) begin
            mem_d[wr_ptr_q] = v_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CW'(push_ok) - CW'(pop);
        // A new overflow outranks a simultaneous status-write clear.
        ovf_d   = (ovf_q && !stat_wr) || ovf_set;
        unf_d   = (unf_q && !stat_wr) || unf_set;
        irq_d   = ovf_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            irq_q    <= 1'b0;
            for (int i = 0; i < NPORTS; i++) latch_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            irq_q    <= irq_d;
            latch_q  <= latch_d;
            mem_q    <= mem_d;
        end
    end

    always_comb begin
        count_w  = 7'(count_q);
        stat_val = {(count_w[6] ? 6'h3F : count_w[5:0]), ovf_q, unf_q};
        rd_val   = hit_stat ? stat_val : 8'h00;
        for (int i = 0; i < NPORTS; i++) begin
            if (off == 8'(i)) rd_val = latch_q[i];
        end
        for (int i = 0; i < NPORTS; i++) port_q[8*i +: 8] = latch_q[i];
    end

    // The drive enable is gated by reset so the shared bus is released the instant reset asserts.
    assign bus.iv_oe      = reset && rd_cyc && (hit_port || hit_stat);
    assign bus.iv_out     = bus.iv_oe ? iv_code(rd_val) : 8'hFF;
    assign bus.fifo_valid = count_q != '0;
    assign bus.fifo_data  = bus.fifo_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign irq            = irq_q;

endmodule

// File: doc/iv_port_bank.md
Name: iv_port_bank

Overview:
- Synthesizable, parametrised peripheral bank for the 8X305 IV bus, clocked by the CPU's MCLK.
- Replaces fixed bench-side LB/RB stimulus with real addressable I/O.
- Provides NPORTS byte-wide output latches with read-back, one optional transmit FIFO port drained by an external ready/valid consumer, and a status/flag port.
- One instance serves one bank; instantiate twice for a left-bank/right-bank pair.

Parameters:
- BANK, 0, bank select this instance answers to: 0 = LB, 1 = RB.
- BASE_ADDR, 8'h00, first IV address decoded by this bank.
- NPORTS, 4, number of byte latch ports (1..16).
- FIFO_PORT, 0, port index whose writes go to the TX FIFO; FIFO_PORT >= NPORTS disables the FIFO.
- FIFO_DEPTH, 4, TX FIFO entries (power of two, 2..64).

Ports:
- clk  in  1  MCLK from S8x305
- reset  in  1  asynchronous, active-low; clears all state
- LB  in  1  left-bank select, active-low
- RB  in  1  right-bank select, active-low
- SC  in  1  select-command strobe (address cycle)
- WC  in  1  write-command strobe (data cycle)
- iv_in  in  8  IV bus as driven by CPU (inverted, bit-reversed)
- iv_out  out  8  IV bus drive value (inverted, bit-reversed)
- iv_oe  out  1  enable for iv_out onto the shared tristate bus
- port_q  out  8*NPORTS  latch contents, port i at [8i+7:8i]
- fifo_data  out  8  TX FIFO head
- fifo_valid  out  1  TX FIFO non-empty
- fifo_ready  in  1  consumer accepts head this cycle
- irq  out  1  high while the overflow sticky flag is set

Behaviour:
- Bus coding: true value v = ~reverse(iv_in). iv_out = ~reverse(v_out).
- sel = (BANK ? !RB : !LB) && (LB != RB). Both selects low means no select.
- Address latch: on posedge with sel && SC, addr_q <= decoded value. Reset value 0x00. addr_q holds until the next qualifying SC.
- Decode: off = addr_q - BASE_ADDR (8-bit, wrapping).
  - hit_port = off < NPORTS.
  - hit_stat = off == NPORTS.
  - Any other address is ignored: no drive, no write.
- Write: on posedge with sel && WC && !SC:
  - Port latch: port_q[off] <= v. This also applies to FIFO_PORT when the FIFO is disabled.
  - Enabled FIFO port: push v; port_q[FIFO_PORT] also updates to v.
  - Status port: any written value clears the ovf and unf flags.
- Read (combinational): iv_oe = sel && !SC && !WC && (hit_port || hit_stat).
  - Port hit: iv_out = encode(port_q[off]).
  - Status hit: iv_out = encode({count[5:0] saturated at 63, ovf, unf}).
  - iv_oe = 0 otherwise. iv_out is 8'hFF when not driving.
- Read of the enabled FIFO port pops nothing. It sets unf if the FIFO is empty during that cycle; unf is latched on posedge.
- FIFO: registered storage with wrapping read/write pointers and a count register.
  - fifo_data = head; fifo_valid = count != 0. fifo_data is 0x00 when empty.
  - pop = fifo_valid && fifo_ready, applied on posedge.
  - Push when full and no pop in the same cycle: data is dropped, ovf <= 1, count unchanged.
  - Push when full with pop in the same cycle: accepted, count unchanged.
  - Push and pop when count == 1: the head advances to the new data; count stays 1.
- Flag priority: a status write that coincides with a new overflow leaves ovf set (set wins).
- irq = ovf, registered.
- Reset (async, any time including mid-cycle): clears addr_q, all port_q, the FIFO pointers and count, ovf, unf and irq. Outputs go to iv_oe=0, iv_out=8'hFF, fifo_valid=0 immediately.
- Latency:
  - Latch and status updates are visible on the bus one clk after the write edge.
  - fifo_valid rises one clk after the push edge.

Test Plan:
- BANK=0, BASE=0: SC with LB=0 and iv_in=~rev(0x02), then WC with iv_in=~rev(0x5A) -> port_q[2]=0x5A; a following read cycle gives iv_oe=1, iv_out=~rev(0x5A)=0xA5.
- Same writes with LB=1, RB=0 -> no latch change; iv_oe=0 throughout. Same check with LB=RB=0.
- FIFO_PORT=0, DEPTH=4, fifo_ready=0: five writes 0x11..0x15 -> count=4, fifo_data=0x11, ovf=1, irq=1. Status read gives {4,1,0} = 0x12 coded.
- Hold fifo_ready=1 with FIFO full while writing 0x16 -> accepted; fifo_data advances to 0x12; count stays 4. Drain -> 0x12, 0x13, 0x14, 0x16, then fifo_valid=0.
- Read FIFO port while empty -> unf=1. Write 0x00 to the status address -> ovf=unf=0, irq=0 next clk.
- Assert reset mid-burst (count=3) -> fifo_valid=0, all port_q=0, iv_oe=0 immediately. After release, addr_q=0 and a read returns 0x00.
